// File: rtl/display_scanner_pkg.sv
// Shared constants for the two-digit display scanner: segment bit order,
// digit-enable codes and scan FSM state encoding.
package display_scanner_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_NONE = 7'b0000000;

    localparam logic [1:0] DIG_OFF = 2'b00;
    localparam logic [1:0] DIG_CXA = 2'b01;
    localparam logic [1:0] DIG_RGA = 2'b10;

    localparam logic [1:0] ST_BLANK = 2'd0;
    localparam logic [1:0] ST_CXA   = 2'd1;
    localparam logic [1:0] ST_RGA   = 2'd2;

    function automatic logic [1:0] digitCode(input logic [1:0] state);
        case (state)
            ST_CXA:  digitCode = DIG_CXA;
            ST_RGA:  digitCode = DIG_RGA;
            default: digitCode = DIG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/display_scanner_timebase.sv
// Slot prescaler and blink timebase: slot count, one-cycle slot pulse on the
// last count, and the alarm blink phase that toggles every BLINK_SLOTS slots.
module scan_timebase #(
    parameter int PRESCALE    = 50000,
    parameter int BLINK_SLOTS = 64,
    parameter int CNT_W       = 16,
    parameter int BLINK_W     = 6
) (
    input  logic             Clock,
    input  logic             Reset_n,
    output logic [CNT_W-1:0] count,
    output logic             slotTick,
    output logic             blinkPhase,
    output logic             blinkWrap
);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   countNext_s;
    logic               slotTick_r;
    logic [BLINK_W-1:0] blinkCnt_r;
    logic               blinkPhase_r;
    logic               blinkWrap_s;

    // Next prescaler value; wraps after the last count of the slot
    always_comb begin
        if (count_r == CNT_LAST) begin
            countNext_s = '0;
        end else begin
            countNext_s = count_r + CNT_W'(1);
        end
    end

    assign blinkWrap_s = slotTick_r && (blinkCnt_r == BLINK_LAST);

    // The slot pulse is registered from the next count so it lines up with count = last
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_r      <= '0;
            slotTick_r   <= 1'b0;
            blinkCnt_r   <= '0;
            blinkPhase_r <= 1'b0;
        end else begin
            count_r    <= countNext_s;
            slotTick_r <= (countNext_s == CNT_LAST);
            if (blinkWrap_s) begin
                blinkCnt_r   <= '0;
                blinkPhase_r <= ~blinkPhase_r;
            end else if (slotTick_r) begin
                blinkCnt_r   <= blinkCnt_r + BLINK_W'(1);
                blinkPhase_r <= blinkPhase_r;
            end else begin
                blinkCnt_r   <= blinkCnt_r;
                blinkPhase_r <= blinkPhase_r;
            end
        end
    end

    assign count      = count_r;
    assign slotTick   = slotTick_r;
    assign blinkPhase = blinkPhase_r;
    assign blinkWrap  = blinkWrap_s;

endmodule

// File: rtl/display_scanner.sv
// Two-digit multiplexed 7-segment scanner (caixa / rega) with a dead-time guard
// at each slot start, once-per-slot pattern capture and alarm blinking.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 4,
    parameter int BLINK_SLOTS = 64
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [SEG_A:SEG_G] SegCaixa,
    input  logic [SEG_A:SEG_G] SegRega,
    input  logic               ModoVarredura,
    input  logic               ChaveSeletora,
    input  logic               Alarme,
    output logic [SEG_A:SEG_G] Segmentos,
    output logic [1:0]         Digito,
    output logic               SlotTick
);

    localparam int CNT_W   = $clog2(PRESCALE);
    localparam int BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD_CYCLES);

    if (PRESCALE < DEAD_CYCLES + 2 || DEAD_CYCLES < 0 || BLINK_SLOTS < 1) begin : g_paramCheck
        $error("display_scanner: illegal PRESCALE/DEAD_CYCLES/BLINK_SLOTS combination");
    end

    logic [CNT_W-1:0]   count_s;
    logic               slotTick_s;
    logic               blinkPhase_s;
    logic               blinkWrap_s;

    logic [1:0]         state_r;
    logic [1:0]         fsmNext_s;
    logic [1:0]         stateNext_s;
    logic [CNT_W-1:0]   countNext_s;
    logic               phaseNext_s;
    logic               captureNext_s;
    logic [6:0]         pattNext_s;
    logic [6:0]         patt_r;
    logic               alarmNext_s;
    logic               alarm_r;
    logic               digitOffNext_s;
    logic               blankNext_s;
    logic [6:0]         segNext_s;
    logic [1:0]         digNext_s;
    logic [6:0]         segmentos_r;
    logic [1:0]         digito_r;

    scan_timebase #(
        .PRESCALE    (PRESCALE),
        .BLINK_SLOTS (BLINK_SLOTS),
        .CNT_W       (CNT_W),
        .BLINK_W     (BLINK_W)
    ) u_timebase (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .count      (count_s),
        .slotTick   (slotTick_s),
        .blinkPhase (blinkPhase_s),
        .blinkWrap  (blinkWrap_s)
    );

    // Slot-boundary successor; an unknown state falls back to BLANK in auto mode
    always_comb begin
        fsmNext_s = ST_BLANK;
        if (ModoVarredura) begin
            case (state_r)
                ST_BLANK: fsmNext_s = ST_CXA;
                ST_CXA:   fsmNext_s = ST_RGA;
                ST_RGA:   fsmNext_s = ST_CXA;
                default:  fsmNext_s = ST_BLANK;
            endcase
        end else if (ChaveSeletora) begin
            fsmNext_s = ST_RGA;
        end else begin
            fsmNext_s = ST_CXA;
        end
    end

    // Everything below looks one cycle ahead so the registered outputs line up with count
    always_comb begin
        stateNext_s = state_r;
        countNext_s = count_s + CNT_W'(1);
        if (slotTick_s) begin
            stateNext_s = fsmNext_s;
            countNext_s = '0;
        end else begin
            stateNext_s = state_r;
            countNext_s = count_s + CNT_W'(1);
        end

        phaseNext_s   = blinkPhase_s ^ blinkWrap_s;
        captureNext_s = (countNext_s == DEAD_CNT);

        pattNext_s  = patt_r;
        alarmNext_s = alarm_r;
        if (captureNext_s) begin
            alarmNext_s = Alarme;
            if (stateNext_s == ST_RGA) begin
                pattNext_s = SegRega;
            end else begin
                pattNext_s = SegCaixa;
            end
        end else begin
            pattNext_s  = patt_r;
            alarmNext_s = alarm_r;
        end

        digitOffNext_s = (stateNext_s == ST_BLANK) || (countNext_s < DEAD_CNT);
        blankNext_s    = alarmNext_s && (stateNext_s == ST_CXA) && phaseNext_s;

        if (digitOffNext_s) begin
            digNext_s = DIG_OFF;
            segNext_s = SEG_NONE;
        end else if (blankNext_s) begin
            digNext_s = digitCode(stateNext_s);
            segNext_s = SEG_NONE;
        end else begin
            digNext_s = digitCode(stateNext_s);
            segNext_s = pattNext_s;
        end
    end

    // Scan state, captured pattern/alarm and output drive registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_BLANK;
            patt_r      <= SEG_NONE;
            alarm_r     <= 1'b0;
            segmentos_r <= SEG_NONE;
            digito_r    <= DIG_OFF;
        end else begin
            state_r     <= stateNext_s;
            patt_r      <= pattNext_s;
            alarm_r     <= alarmNext_s;
            segmentos_r <= segNext_s;
            digito_r    <= digNext_s;
        end
    end

    assign Segmentos = segmentos_r;
    assign Digito    = digito_r;
    assign SlotTick  = slotTick_s;

endmodule
